// File: rtl/axis_pkt_fifo.sv
// Purpose: single-clock AXI-Stream FIFO with optional store-and-forward packet mode and drop accounting.
// Latency: cut-through word visible one edge after it is written; packet mode one edge after its tlast is written.
// Backpressure: s_axis_in_tready = !full; words arriving while full are dropped, counted and flagged.
//
// Ports:
//   clk_i, reset_ni          single clock, synchronous active-low reset
//   s_axis_in_*              write side; tready/tfull/talmost_full are status from registered pointers
//   m_axis_out_*             registered first-word-fall-through read side; tlevel/tempty status
//   overflow_o               sticky flag, set by any dropped word
//   drop_count_o             saturating count of dropped words
module axis_pkt_fifo #(
  parameter int DATA_WIDTH        = 16,
  parameter int USER_WIDTH        = 1,
  parameter int FIFO_LEN          = 16,
  parameter int PACKET_MODE       = 0,
  parameter int ALMOST_FULL_LEVEL = FIFO_LEN - 2
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [DATA_WIDTH-1:0]     s_axis_in_tdata,
  input  logic [USER_WIDTH-1:0]     s_axis_in_tuser,
  input  logic                      s_axis_in_tlast,
  input  logic                      s_axis_in_tvalid,
  output logic                      s_axis_in_tready,
  output logic                      s_axis_in_tfull,
  output logic                      s_axis_in_talmost_full,
  input  logic                      m_axis_out_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_out_tdata,
  output logic [USER_WIDTH-1:0]     m_axis_out_tuser,
  output logic                      m_axis_out_tlast,
  output logic                      m_axis_out_tvalid,
  output logic [$clog2(FIFO_LEN):0] m_axis_out_tlevel,
  output logic                      m_axis_out_tempty,
  output logic                      overflow_o,
  output logic [15:0]               drop_count_o
);

  localparam int PTR_WIDTH = $clog2(FIFO_LEN);

  typedef logic [PTR_WIDTH:0] ptr_t;

  typedef struct packed {
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {ACCEPT, DISCARD} state_t;

  localparam ptr_t FULL_LEVEL = ptr_t'(FIFO_LEN);
  localparam ptr_t AF_LEVEL   = ptr_t'(ALMOST_FULL_LEVEL);

  entry_t      mem [FIFO_LEN];
  entry_t      wr_entry;
  entry_t      rd_entry;

  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  ptr_t        commit_ptr;
  ptr_t        wr_ptr_d;
  ptr_t        commit_ptr_d;
  ptr_t        level;
  ptr_t        pending;
  state_t      state;
  state_t      state_d;

  logic        full;
  logic        readable;
  logic        load;
  logic        wr_en;
  logic [16:0] drop_inc;
  logic [16:0] drop_sum;

  // Status is derived from registered pointers only, never from this cycle's inputs.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LEVEL);
  assign pending  = wr_ptr - commit_ptr;
  // commit_ptr equals wr_ptr in cut-through mode, so one test covers both modes.
  assign readable = (rd_ptr != commit_ptr);
  assign load     = readable && (!m_axis_out_tvalid || m_axis_out_tready);

  assign s_axis_in_tready       = !full;
  assign s_axis_in_tfull        = full;
  assign s_axis_in_talmost_full = (level >= AF_LEVEL);
  assign m_axis_out_tlevel      = level;
  assign m_axis_out_tempty      = (level == '0) && !m_axis_out_tvalid;

  assign wr_entry = '{last: s_axis_in_tlast, user: s_axis_in_tuser, data: s_axis_in_tdata};
  assign rd_entry = mem[rd_ptr[PTR_WIDTH-1:0]];
  assign drop_sum = {1'b0, drop_count_o} + drop_inc;

  // Write-side decisions and the packet-mode ACCEPT/DISCARD machine.
  always_comb begin
    wr_en        = 1'b0;
    wr_ptr_d     = wr_ptr;
    commit_ptr_d = commit_ptr;
    state_d      = state;
    drop_inc     = '0;
    if (s_axis_in_tvalid) begin
      if (PACKET_MODE != 0 && state == DISCARD) begin
        // Tail of a packet that already lost words: drop everything up to its tlast.
        drop_inc = 17'd1;
        if (s_axis_in_tlast) state_d = ACCEPT;
      end else if (full) begin
        if (PACKET_MODE != 0) begin
          // Rewind the partial packet; its stored words count as dropped too.
          drop_inc = 17'(pending) + 17'd1;
          wr_ptr_d = commit_ptr;
          if (!s_axis_in_tlast) state_d = DISCARD;
        end else begin
          drop_inc = 17'd1;
        end
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr + ptr_t'(1);
        if (PACKET_MODE == 0 || s_axis_in_tlast) commit_ptr_d = wr_ptr + ptr_t'(1);
      end
    end
  end

  // Storage is not reset; only pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[PTR_WIDTH-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      commit_ptr        <= '0;
      state             <= ACCEPT;
      overflow_o        <= 1'b0;
      drop_count_o      <= '0;
      m_axis_out_tvalid <= 1'b0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tuser  <= '0;
      m_axis_out_tlast  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      commit_ptr <= commit_ptr_d;
      state      <= state_d;
      if (drop_inc != '0) begin
        overflow_o   <= 1'b1;
        drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      if (load) begin
        rd_ptr            <= rd_ptr + ptr_t'(1);
        m_axis_out_tvalid <= 1'b1;
        m_axis_out_tdata  <= rd_entry.data;
        m_axis_out_tuser  <= rd_entry.user;
        m_axis_out_tlast  <= rd_entry.last;
      end else if (m_axis_out_tready) begin
        m_axis_out_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
`timescale 1ns/1ps
module tb_axis_pkt_fifo;
  localparam int N = 8;

  typedef struct packed {
    logic        last;
    logic        usr;
    logic [15:0] dat;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0: cut-through instance, index 1: packet-mode instance.
  logic [15:0] in_dat   [2];
  logic        in_usr   [2];
  logic        in_last  [2];
  logic        in_vld   [2];
  logic        in_rdy   [2];
  logic        in_full  [2];
  logic        in_af    [2];
  logic        out_rdy  [2];
  logic [15:0] out_dat  [2];
  logic        out_usr  [2];
  logic        out_last [2];
  logic        out_vld  [2];
  logic [3:0]  out_lvl  [2];
  logic        out_empty[2];
  logic        ovf      [2];
  logic [15:0] drops    [2];

  axis_pkt_fifo #(.DATA_WIDTH(16), .USER_WIDTH(1), .FIFO_LEN(N), .PACKET_MODE(0), .ALMOST_FULL_LEVEL(N-2)) u_ct (
    .clk_i(clk), .reset_ni(rst_n),
    .s_axis_in_tdata(in_dat[0]), .s_axis_in_tuser(in_usr[0]), .s_axis_in_tlast(in_last[0]),
    .s_axis_in_tvalid(in_vld[0]), .s_axis_in_tready(in_rdy[0]), .s_axis_in_tfull(in_full[0]),
    .s_axis_in_talmost_full(in_af[0]), .m_axis_out_tready(out_rdy[0]), .m_axis_out_tdata(out_dat[0]),
    .m_axis_out_tuser(out_usr[0]), .m_axis_out_tlast(out_last[0]), .m_axis_out_tvalid(out_vld[0]),
    .m_axis_out_tlevel(out_lvl[0]), .m_axis_out_tempty(out_empty[0]), .overflow_o(ovf[0]),
    .drop_count_o(drops[0])
  );

  axis_pkt_fifo #(.DATA_WIDTH(16), .USER_WIDTH(1), .FIFO_LEN(N), .PACKET_MODE(1), .ALMOST_FULL_LEVEL(N-2)) u_pk (
    .clk_i(clk), .reset_ni(rst_n),
    .s_axis_in_tdata(in_dat[1]), .s_axis_in_tuser(in_usr[1]), .s_axis_in_tlast(in_last[1]),
    .s_axis_in_tvalid(in_vld[1]), .s_axis_in_tready(in_rdy[1]), .s_axis_in_tfull(in_full[1]),
    .s_axis_in_talmost_full(in_af[1]), .m_axis_out_tready(out_rdy[1]), .m_axis_out_tdata(out_dat[1]),
    .m_axis_out_tuser(out_usr[1]), .m_axis_out_tlast(out_last[1]), .m_axis_out_tvalid(out_vld[1]),
    .m_axis_out_tlevel(out_lvl[1]), .m_axis_out_tempty(out_empty[1]), .overflow_o(ovf[1]),
    .drop_count_o(drops[1])
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a list of stored words per instance, of which the first mcom are
  // readable, plus the output register contents and the drop bookkeeping.
  word_t mq [2][N];
  int    msz  [2];
  int    mcom [2];
  int    mdrop[2];
  bit    movld[2];
  bit    mdisc[2];
  bit    movf [2];
  word_t mout [2];
  bit    hold_prev[2];
  word_t prev_out [2];
  word_t got0[$];
  word_t got1[$];

  task automatic lose(input int i, input int n);
    movf[i]  = 1'b1;
    mdrop[i] = (mdrop[i] + n > 65535) ? 65535 : mdrop[i] + n;
  endtask

  // Predicts the state after the coming rising edge from the inputs now applied.
  task automatic model_step(input int i);
    bit    was_full;
    word_t w;
    if (!rst_n) begin
      msz[i] = 0; mcom[i] = 0; mdrop[i] = 0;
      movld[i] = 1'b0; mdisc[i] = 1'b0; movf[i] = 1'b0; mout[i] = '0;
      return;
    end
    was_full = (msz[i] == N);
    if (mcom[i] > 0 && (!movld[i] || out_rdy[i])) begin
      mout[i] = mq[i][0];
      for (int j = 0; j < N-1; j++) mq[i][j] = mq[i][j+1];
      msz[i]--; mcom[i]--; movld[i] = 1'b1;
    end else if (out_rdy[i]) begin
      movld[i] = 1'b0;
    end
    if (in_vld[i]) begin
      w = {in_last[i], in_usr[i], in_dat[i]};
      if (mdisc[i]) begin
        lose(i, 1);
        if (w.last) mdisc[i] = 1'b0;
      end else if (was_full) begin
        if (i == 1) begin
          lose(i, msz[i] - mcom[i] + 1);
          msz[i] = mcom[i];
          if (!w.last) mdisc[i] = 1'b1;
        end else begin
          lose(i, 1);
        end
      end else begin
        mq[i][msz[i]] = w;
        msz[i]++;
        if (i == 0 || w.last) mcom[i] = msz[i];
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (chk_en) begin
        chk($sformatf("d%0d tvalid", i), out_vld[i], movld[i]);
        if (movld[i]) begin
          chk($sformatf("d%0d tdata", i), out_dat[i], mout[i].dat);
          chk($sformatf("d%0d tlast", i), out_last[i], mout[i].last);
          chk($sformatf("d%0d tuser", i), out_usr[i], mout[i].usr);
        end
        if (hold_prev[i])
          chk($sformatf("d%0d held word stable", i), {out_last[i], out_usr[i], out_dat[i]}, prev_out[i]);
        chk($sformatf("d%0d tlevel", i), out_lvl[i], msz[i]);
        chk($sformatf("d%0d tempty", i), out_empty[i], (msz[i] == 0 && !movld[i]));
        chk($sformatf("d%0d tfull", i), in_full[i], (msz[i] == N));
        chk($sformatf("d%0d talmost_full", i), in_af[i], (msz[i] >= N-2));
        chk($sformatf("d%0d tready", i), in_rdy[i], (msz[i] != N));
        chk($sformatf("d%0d overflow", i), ovf[i], movf[i]);
        chk($sformatf("d%0d drop_count", i), drops[i], mdrop[i]);
        hold_prev[i] = out_vld[i] && !out_rdy[i] && rst_n;
        prev_out[i]  = {out_last[i], out_usr[i], out_dat[i]};
        if (out_vld[i] && out_rdy[i] && rst_n) begin
          if (i == 0) got0.push_back({out_last[i], out_usr[i], out_dat[i]});
          else        got1.push_back({out_last[i], out_usr[i], out_dat[i]});
        end
      end
      model_step(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic v, input logic [15:0] d, input logic l);
    in_vld[i]  = v;
    in_dat[i]  = d;
    in_usr[i]  = d[0];
    in_last[i] = l;
  endtask

  task automatic wait_got(input int i, input int n, input int budget);
    int k = 0;
    while (((i == 0) ? got0.size() : got1.size()) < n && k < budget) begin
      tick();
      k++;
    end
    chk($sformatf("d%0d drained word count", i), (i == 0) ? got0.size() : got1.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      put(i, 1'b0, 16'd0, 1'b0);
      out_rdy[i] = 1'b1;
    end
    tick();
    tick();
    chk("reset tvalid", out_vld[0], 0);
    chk("reset tempty", out_empty[0], 1);
    chk("reset tready", in_rdy[0], 1);
    chk("reset tlevel", out_lvl[0], 0);
    chk("reset tdata", out_dat[0], 0);
    chk("reset talmost_full", in_af[0], 0);
    chk("reset drop_count", drops[0], 0);
    chk("reset pk tvalid", out_vld[1], 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Cut-through fill with the reader stalled. The output register takes word 0,
    // so memory reaches full on the 9th word and words 9 and 10 are dropped.
    out_rdy[0] = 1'b0;
    for (int w = 0; w < 11; w++) begin
      put(0, 1'b1, 16'(w), (w == 7));
      tick();
      if (w == 0) chk("ct first word not yet visible", out_vld[0], 0);
      if (w == 1) chk("ct tvalid one edge after first write", out_vld[0], 1);
      if (w == 7) chk("ct not full after 8 words", in_full[0], 0);
      if (w == 8) chk("ct full after 9 words", in_full[0], 1);
    end
    put(0, 1'b0, 16'd0, 1'b0);
    tick();
    chk("ct overflow set", ovf[0], 1);
    chk("ct drop_count", drops[0], 2);
    chk("ct level while stalled", out_lvl[0], 8);
    chk("ct head word", out_dat[0], 0);
    got0.delete();
    out_rdy[0] = 1'b1;
    wait_got(0, 9, 30);
    for (int j = 0; j < got0.size(); j++) begin
      chk($sformatf("ct out word %0d", j), got0[j].dat, j);
      chk($sformatf("ct out last %0d", j), got0[j].last, (j == 7));
    end
    chk("ct empty after drain", out_empty[0], 1);

    // Packet mode: nothing is visible until the tlast word is stored.
    got1.delete();
    for (int w = 0; w < 5; w++) begin
      put(1, 1'b1, 16'(100 + w), (w == 4));
      tick();
      chk($sformatf("pk held before commit %0d", w), out_vld[1], 0);
    end
    put(1, 1'b0, 16'd0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("pk burst valid %0d", j), out_vld[1], 1);
      chk($sformatf("pk burst data %0d", j), out_dat[1], 100 + j);
      chk($sformatf("pk burst last %0d", j), out_last[1], (j == 4));
    end
    tick();
    chk("pk valid drops after packet", out_vld[1], 0);

    // Oversized packet is discarded whole; the following short packet survives.
    got1.delete();
    for (int w = 0; w < 12; w++) begin
      put(1, 1'b1, 16'(300 + w), (w == 11));
      tick();
    end
    chk("pk level after discard", out_lvl[1], 0);
    for (int w = 0; w < 3; w++) begin
      put(1, 1'b1, 16'(200 + w), (w == 2));
      tick();
    end
    put(1, 1'b0, 16'd0, 1'b0);
    wait_got(1, 3, 20);
    for (int j = 0; j < got1.size(); j++) begin
      chk($sformatf("pk survivor word %0d", j), got1[j].dat, 200 + j);
      chk($sformatf("pk survivor last %0d", j), got1[j].last, (j == 2));
    end
    chk("pk drop_count", drops[1], 12);
    chk("pk overflow", ovf[1], 1);

    // Random valid/ready, writes only when tready is high, so nothing is lost.
    got0.delete();
    begin
      int sent = 0;
      int k = 0;
      while (sent < 1000 && k < 20000) begin
        out_rdy[0] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1 && in_rdy[0]) begin
          put(0, 1'b1, 16'(sent), (sent % 7 == 6));
          sent++;
        end else begin
          put(0, 1'b0, 16'd0, 1'b0);
        end
        tick();
        k++;
      end
      chk("random words sent", sent, 1000);
    end
    put(0, 1'b0, 16'd0, 1'b0);
    out_rdy[0] = 1'b1;
    wait_got(0, 1000, 100);
    for (int j = 0; j < got0.size(); j++) begin
      chk($sformatf("random word %0d", j), got0[j].dat, j);
      chk($sformatf("random last %0d", j), got0[j].last, (j % 7 == 6));
    end
    chk("random no new drops", drops[0], 2);

    // Reset while holding words: everything is forgotten, new data comes out first.
    out_rdy[0] = 1'b0;
    for (int w = 0; w < 5; w++) begin
      put(0, 1'b1, 16'(500 + w), 1'b0);
      tick();
    end
    put(0, 1'b0, 16'd0, 1'b0);
    chk("held words in memory", out_lvl[0], 4);
    rst_n = 1'b0;
    tick();
    chk("after reset tlevel", out_lvl[0], 0);
    chk("after reset tempty", out_empty[0], 1);
    chk("after reset tvalid", out_vld[0], 0);
    chk("after reset overflow", ovf[0], 0);
    chk("after reset drop_count", drops[0], 0);
    rst_n = 1'b1;
    out_rdy[0] = 1'b1;
    got0.delete();
    put(0, 1'b1, 16'd777, 1'b1);
    tick();
    put(0, 1'b0, 16'd0, 1'b0);
    wait_got(0, 1, 10);
    if (got0.size() > 0) chk("first word after reset", got0[0].dat, 777);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
